sci_to_cycle: RTL and testbench

Converts a scientific-notation period (3-digit mantissa plus decimal exponent, the form shown on the OLED) back into a raw cycle count in 0.01 us units. Sits between the button/OLED entry path and the cymometer, so user-entered thresholds and reference periods can be compared directly against measured `cycle_fx` values. Scaling is iterative, one multiply-by-10 per clock, with valid/ready handshakes on both sides.

---
 rtl/sci_to_cycle.sv | 117 +++++++++++
 tb/tb_sci_to_cycle.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sci_to_cycle.sv
// sci_to_cycle: converts a scientific-notation period (mantissa * 10^unit)
// into a raw cycle count in 0.01 us units. One multiply-by-10 per clock,
// saturating to all-ones on overflow, with valid/ready on both sides.
module sci_to_cycle #(
  parameter int CYCLE_W  = 30,
  parameter int MANT_W   = 10,
  parameter int UNIT_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W-1:0]  mantissa,
  input  logic [3:0]         unit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CYCLE_W-1:0] cycle_fx,
  output logic               overflow,
  output logic               err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCALE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] UNIT_MAX_L = 4'(UNIT_MAX);

  logic [1:0]         r_state;
  logic [CYCLE_W-1:0] r_acc;
  logic [3:0]         r_cnt;
  logic               r_overflow;
  logic               r_err;

  // {saturated flag, value}
  logic [CYCLE_W:0]   w_mul;

  // acc*10 as shift-add with 4 guard bits; anything landing in the guard
  // bits exceeds the result range and saturates to all-ones.
  function automatic logic [CYCLE_W:0] mul10_sat(input logic [CYCLE_W-1:0] a);
    logic [CYCLE_W+3:0] ext;
    logic [CYCLE_W+3:0] prod;
    ext  = {4'b0000, a};
    prod = (ext << 3) + (ext << 1);
    if (|prod[CYCLE_W+3:CYCLE_W]) begin
      return {1'b1, {CYCLE_W{1'b1}}};
    end
    return {1'b0, prod[CYCLE_W-1:0]};
  endfunction

  // Next scaling step of the accumulator
  always_comb begin
    w_mul = mul10_sat(r_acc);
  end

  // Control FSM and result registers; a new request clears the status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc      <= {{(CYCLE_W-MANT_W){1'b0}}, mantissa};
            r_cnt      <= unit;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
            if (unit > UNIT_MAX_L) begin
              r_err   <= 1'b1;
              r_acc   <= '0;
              r_state <= S_DONE;
            end else if (unit == 4'd0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_SCALE;
            end
          end
        end
        S_SCALE: begin
          if (w_mul[CYCLE_W]) begin
            // saturated: remaining multiplies would change nothing
            r_acc      <= w_mul[CYCLE_W-1:0];
            r_overflow <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_acc <= w_mul[CYCLE_W-1:0];
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs; in_ready is held low for the whole reset window
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE);
    cycle_fx  = r_acc;
    overflow  = r_overflow;
    err       = r_err;
  end

endmodule

// File: tb/tb_sci_to_cycle.sv
// Directed bench for sci_to_cycle with an expected-result queue.
module tb_sci_to_cycle;

  localparam int     CYCLE_W  = 30;
  localparam int     MANT_W   = 10;
  localparam int     UNIT_MAX = 8;
  localparam longint MAXV     = (64'd1 << CYCLE_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [MANT_W-1:0]  mantissa = '0;
  logic [3:0]         unit = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [CYCLE_W-1:0] cycle_fx;
  logic               overflow;
  logic               err;

  typedef struct {
    longint c;
    bit     o;
    bit     e;
    int     lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sci_to_cycle #(.CYCLE_W(CYCLE_W), .MANT_W(MANT_W), .UNIT_MAX(UNIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mantissa(mantissa), .unit(unit),
    .out_valid(out_valid), .out_ready(out_ready),
    .cycle_fx(cycle_fx), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal scaling with saturation, plus expected latency
  function automatic exp_t model(input int m, input int u);
    exp_t   r;
    longint v;
    r.o = 1'b0;
    r.e = 1'b0;
    if (u > UNIT_MAX) begin
      r.c   = 0;
      r.e   = 1'b1;
      r.lat = 1;
      return r;
    end
    v     = m;
    r.lat = u + 1;
    for (int j = 1; j <= u; j++) begin
      v = v * 10;
      if (v > MAXV) begin
        v     = MAXV;
        r.o   = 1'b1;
        r.lat = j + 1;
        break;
      end
    end
    r.c = v;
    return r;
  endfunction

  // Issue one request, wait for the result, hold it off for 'hold' cycles
  task automatic request(input int m, input int u, input int hold, input string tag);
    exp_t e;
    int   n;
    chk({tag, ".in_ready_pre"}, in_ready, 1);
    in_valid = 1'b1;
    mantissa = m[MANT_W-1:0];
    unit     = u[3:0];
    sb.push_back(model(m, u));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".out_valid"}, out_valid, 1);
    e = sb.pop_front();
    if (!out_valid) return;
    chk({tag, ".latency"}, n + 1, e.lat);
    chk({tag, ".cycle_fx"}, cycle_fx, e.c);
    chk({tag, ".overflow"}, overflow, e.o);
    chk({tag, ".err"}, err, e.e);
    chk({tag, ".in_ready_busy"}, in_ready, 0);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid = (i % 2 == 0);
        mantissa = 1;
        unit     = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".hold_valid"}, out_valid, 1);
        chk({tag, ".hold_cycle"}, cycle_fx, e.c);
        chk({tag, ".hold_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ".out_valid_post"}, out_valid, 0);
    chk({tag, ".in_ready_post"}, in_ready, 1);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cycle_fx", cycle_fx, 0);
    chk("rst.overflow", overflow, 0);
    chk("rst.err", err, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready_release", in_ready, 1);
    @(posedge clk); #1;

    // main function
    request(123, 0, 0, "m123u0");
    request(456, 3, 0, "m456u3");
    request(999, 6, 0, "m999u6");
    request(1023, 6, 0, "m1023u6");
    // overflow boundary
    request(10, 8, 0, "m10u8");
    request(11, 8, 0, "m11u8_ovf");
    request(1023, 7, 0, "m1023u7_ovf");
    // illegal exponent, then a legal request clears err
    request(5, 9, 0, "m5u9_err");
    request(5, 2, 0, "m5u2_clr");
    // backpressure with ignored input pulses
    request(7, 2, 6, "m7u2_bp");

    // reset in the middle of scaling
    chk("mid.in_ready_pre", in_ready, 1);
    in_valid = 1'b1;
    mantissa = 10'd999;
    unit     = 4'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid.cycle_fx", cycle_fx, 0);
    chk("mid.overflow", overflow, 0);
    chk("mid.err", err, 0);
    chk("mid.out_valid", out_valid, 0);
    chk("mid.in_ready_rst", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid.in_ready_release", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("mid.no_valid", out_valid, 0);
    end
    request(1, 1, 0, "mid_fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
